// File: rtl/hwpe_stream_tcdm_responder_pkg.sv
// ============================================================================
// hwpe_stream_package : shared TCDM widths, stall LFSR constants, request type
// Revision 1.0
// ============================================================================
`default_nettype none

package hwpe_stream_package;

   localparam int HWPE_TCDM_DATA_W = 32;
   localparam int HWPE_TCDM_BE_W   = 4;
   localparam int HWPE_TCDM_ADDR_W = 32;
   localparam int LFSR_W           = 16;

   // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   typedef struct packed {
      logic [HWPE_TCDM_ADDR_W-1:0] add;
      logic                        wen;
      logic [HWPE_TCDM_BE_W-1:0]   be;
      logic [HWPE_TCDM_DATA_W-1:0] data;
   } tcdm_req_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_intf_tcdm.sv
// ============================================================================
// hwpe_stream_intf_tcdm : TCDM request/response bundle with master/slave views
// Revision 1.0
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_tcdm;
   import hwpe_stream_package::*;

   logic                        req;
   logic                        gnt;
   logic [HWPE_TCDM_ADDR_W-1:0] add;
   logic                        wen;
   logic [HWPE_TCDM_BE_W-1:0]   be;
   logic [HWPE_TCDM_DATA_W-1:0] data;
   logic [HWPE_TCDM_DATA_W-1:0] r_data;
   logic                        r_valid;

   modport master (output req, add, wen, be, data, input  gnt, r_data, r_valid);
   modport slave  (input  req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

`default_nettype wire

// File: rtl/hwpe_stream_tcdm_responder_bank.sv
// ============================================================================
// hwpe_stream_tcdm_responder_bank : single-port word array, byte-enable write,
// registered read data, no reset (drop-in point for a memory macro)
// Revision 1.0
// ============================================================================
`default_nettype none

module hwpe_stream_tcdm_responder_bank
   import hwpe_stream_package::*;
#(
   parameter int NB_WORDS = 1024,
   localparam int AW      = $clog2(NB_WORDS)
) (
   input  logic                        clk,
   input  logic                        en,
   input  logic                        we,
   input  logic [AW-1:0]               addr,
   input  logic [HWPE_TCDM_BE_W-1:0]   be,
   input  logic [HWPE_TCDM_DATA_W-1:0] wdata,
   output logic [HWPE_TCDM_DATA_W-1:0] rdata
);

   logic [HWPE_TCDM_DATA_W-1:0] mem [NB_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < HWPE_TCDM_BE_W; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/hwpe_stream_tcdm_responder.sv
// ============================================================================
// hwpe_stream_tcdm_responder : TCDM slave with one-cycle read response,
// grant logic, transaction counters and optional random grant throttling
// (enabled by HWPE_TCDM_RESPONDER_STALL_EN).  Revision 1.0
// ============================================================================
`default_nettype none

module hwpe_stream_tcdm_responder
   import hwpe_stream_package::*;
#(
   parameter int          NB_WORDS  = 1024,
   parameter int          MAX_STALL = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   hwpe_stream_intf_tcdm.slave  tcdm,
   input  logic [3:0]           stall_prob_i,
   output logic [31:0]          nb_reads_o,
   output logic [31:0]          nb_writes_o
);

   localparam int AW = $clog2(NB_WORDS);

   tcdm_req_t                   req_s;
   logic                        deny;
   logic                        gnt;
   logic                        rd_grant;
   logic                        wr_grant;
   logic                        valid_q;
   logic [HWPE_TCDM_DATA_W-1:0] bank_rdata;
   logic [HWPE_TCDM_DATA_W-1:0] rdata_hold;
   logic                        unused_addr;

   assign req_s    = '{add: tcdm.add, wen: tcdm.wen, be: tcdm.be, data: tcdm.data};
   assign gnt      = tcdm.req & ~clear_i & ~deny;
   assign rd_grant = gnt &  req_s.wen;
   assign wr_grant = gnt & ~req_s.wen;

   assign unused_addr = ^{req_s.add[HWPE_TCDM_ADDR_W-1:AW+2], req_s.add[1:0]};

   hwpe_stream_tcdm_responder_bank #(
      .NB_WORDS (NB_WORDS)
   ) i_bank (
      .clk   (clk_i),
      .en    (gnt),
      .we    (~req_s.wen),
      .addr  (req_s.add[AW+1:2]),
      .be    (req_s.be),
      .wdata (req_s.data),
      .rdata (bank_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q     <= 1'b0;
         rdata_hold  <= '0;
         nb_reads_o  <= '0;
         nb_writes_o <= '0;
      end else if (clear_i) begin
         valid_q     <= 1'b0;
         rdata_hold  <= '0;
         nb_reads_o  <= '0;
         nb_writes_o <= '0;
      end else begin
         valid_q <= rd_grant;
         if (valid_q)  rdata_hold  <= bank_rdata;
         if (rd_grant) nb_reads_o  <= nb_reads_o + 32'd1;
         if (wr_grant) nb_writes_o <= nb_writes_o + 32'd1;
      end
   end

   // Clear suppresses a response already in flight, so valid is gated here too.
   assign tcdm.gnt     = gnt;
   assign tcdm.r_valid = valid_q & ~clear_i;
   assign tcdm.r_data  = tcdm.r_valid ? bank_rdata : rdata_hold;

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
   localparam int STALL_W = $clog2(MAX_STALL + 1);

   logic [LFSR_W-1:0]  lfsr;
   logic [STALL_W-1:0] stall_cnt;

   assign deny = (lfsr[3:0] < stall_prob_i) && (stall_cnt < STALL_W'(MAX_STALL));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr      <= LFSR_SEED;
         stall_cnt <= '0;
      end else if (clear_i) begin
         lfsr      <= LFSR_SEED;
         stall_cnt <= '0;
      end else begin
         if (tcdm.req) lfsr <= lfsr_next(lfsr);
         if (tcdm.req & ~gnt) stall_cnt <= stall_cnt + 1'b1;
         else                 stall_cnt <= '0;
      end
   end
`else
   logic unused_stall;

   assign deny         = 1'b0;
   assign unused_stall = ^{stall_prob_i, LFSR_SEED, 32'(MAX_STALL)};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// ============================================================================
// tb_hwpe_stream_tcdm_responder : directed stimulus with a scoreboard queue
// popped by an independent response monitor.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_hwpe_stream_tcdm_responder;

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
   localparam int SMAX = 8;
`else
   localparam int SMAX = 0;
`endif

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        clear;
   logic [3:0]  stall_prob;
   logic [31:0] nb_reads;
   logic [31:0] nb_writes;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   run      = 0;
   exp_t sb[$];

   hwpe_stream_intf_tcdm tcdm_if ();

   hwpe_stream_tcdm_responder #(
      .NB_WORDS  (1024),
      .MAX_STALL (8),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .tcdm         (tcdm_if),
      .stall_prob_i (stall_prob),
      .nb_reads_o   (nb_reads),
      .nb_writes_o  (nb_writes)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input bit ok, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Response monitor: samples late in each cycle, as a master would at the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (tcdm_if.r_valid === 1'b1) begin
            run++;
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_rvalid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk(tcdm_if.r_data === e.data, "rdata", tcdm_if.r_data, e.data);
               chk(cyc == e.cyc, "rvalid_latency", 32'(cyc), 32'(e.cyc));
            end
         end else begin
            run = 0;
         end
      end
   end

   // Called at a falling edge; holds the request until granted, returns at the next falling edge.
   task automatic xfer(input logic rd, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp,
                       input bit expect_resp, input int max_stall);
      int waits;
      waits        = 0;
      tcdm_if.req  = 1'b1;
      tcdm_if.wen  = rd;
      tcdm_if.add  = a;
      tcdm_if.be   = b;
      tcdm_if.data = d;
      #1;
      while (tcdm_if.gnt !== 1'b1 && waits < 40) begin
         @(negedge clk);
         #1;
         waits++;
      end
      chk(waits <= max_stall, "stall_bound", 32'(waits), 32'(max_stall));
      if (tcdm_if.gnt === 1'b1 && rd && expect_resp)
         sb.push_back('{data: exp, cyc: cyc + 1});
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      clear        = 1'b0;
      stall_prob   = 4'd0;
      tcdm_if.req  = 1'b0;
      tcdm_if.wen  = 1'b1;
      tcdm_if.add  = '0;
      tcdm_if.be   = '0;
      tcdm_if.data = '0;

      #2;
      chk(tcdm_if.r_valid === 1'b0, "reset_rvalid", 32'(tcdm_if.r_valid), 32'd0);
      chk(tcdm_if.r_data === 32'd0, "reset_rdata", tcdm_if.r_data, 32'd0);
      chk(nb_reads === 32'd0, "reset_nb_reads", nb_reads, 32'd0);
      chk(nb_writes === 32'd0, "reset_nb_writes", nb_writes, 32'd0);
      chk(tcdm_if.gnt === 1'b0, "reset_gnt", 32'(tcdm_if.gnt), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Write then immediate readback of the same word
      xfer(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      xfer(1'b1, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 0);
      tcdm_if.req = 1'b0;
      chk(nb_writes === 32'd1, "t1_nb_writes", nb_writes, 32'd1);
      chk(nb_reads === 32'd1, "t1_nb_reads", nb_reads, 32'd1);
      @(negedge clk);

      // Partial byte-enable write; byte 0 and 2 replaced
      xfer(1'b0, 32'h10, 4'b0101, 32'h11223344, 32'h0, 1'b0, 0);
      xfer(1'b1, 32'h13, 4'h0, 32'h0, 32'hDE22BE44, 1'b1, 0);

      // Address 0x1000 aliases word 0
      xfer(1'b0, 32'h1000, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, 0);
      xfer(1'b1, 32'h0, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b1, 0);

      // Back-to-back reads of words 0..7
      for (int i = 0; i < 8; i++)
         xfer(1'b0, 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i), 32'h0, 1'b0, 0);
      for (int i = 0; i < 8; i++)
         xfer(1'b1, 32'(i * 4), 4'hF, 32'h0, 32'hC0DE0000 + 32'(i), 1'b1, 0);
      tcdm_if.req = 1'b0;
      #3;
      chk(run == 8, "b2b_rvalid_run", 32'(run), 32'd8);
      chk(nb_reads === 32'd11, "b2b_nb_reads", nb_reads, 32'd11);
      @(negedge clk);

      // Heavy grant throttling
      stall_prob = 4'd15;
      for (int i = 0; i < 8; i++)
         xfer(1'b1, 32'(i * 4), 4'hF, 32'h0, 32'hC0DE0000 + 32'(i), 1'b1, SMAX);
      tcdm_if.req = 1'b0;
      stall_prob  = 4'd0;
      repeat (2) @(negedge clk);

      // Clear on the response cycle of a granted read
      xfer(1'b1, 32'h10, 4'hF, 32'h0, 32'h0, 1'b0, 0);
      clear       = 1'b1;
      tcdm_if.req = 1'b0;
      @(negedge clk);
      chk(nb_reads === 32'd0, "clear_nb_reads", nb_reads, 32'd0);
      chk(nb_writes === 32'd0, "clear_nb_writes", nb_writes, 32'd0);
      chk(tcdm_if.r_data === 32'd0, "clear_rdata", tcdm_if.r_data, 32'd0);
      clear = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of the response cycle
      tcdm_if.req = 1'b1;
      tcdm_if.wen = 1'b1;
      tcdm_if.add = 32'h10;
      #1;
      chk(tcdm_if.gnt === 1'b1, "pre_reset_gnt", 32'(tcdm_if.gnt), 32'd1);
      @(posedge clk);
      #2;
      tcdm_if.req = 1'b0;
      rst         = 1'b1;
      #1;
      chk(tcdm_if.r_valid === 1'b0, "async_reset_rvalid", 32'(tcdm_if.r_valid), 32'd0);
      chk(nb_reads === 32'd0, "async_reset_nb_reads", nb_reads, 32'd0);
      chk(tcdm_if.r_data === 32'd0, "async_reset_rdata", tcdm_if.r_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      repeat (3) @(negedge clk);
      chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
